// File: rtl/host_instr_unpacker_if.sv
// Host FIFO read port and application instruction handshake of the instruction unpacker.
// The master modport is the unpacker side; the slave modport is the FIFO/consumer side.
interface host_instr_unpacker_if #(
  parameter int HOST_W = 128
);
  logic              host_valid;
  logic [HOST_W-1:0] host_data;
  logic              host_rd;
  logic              app_en;
  logic [31:0]       app_instr;
  logic              app_ack;

  modport master (
    input  host_valid,
    input  host_data,
    output host_rd,
    output app_en,
    output app_instr,
    input  app_ack
  );

  modport slave (
    output host_valid,
    output host_data,
    input  host_rd,
    input  app_en,
    input  app_instr,
    output app_ack
  );
endinterface

// File: rtl/host_instr_unpacker.sv
// Splits wide host FIFO words into 32-bit instructions, skipping pad slots and
// dropping the tail of a word after an end-of-sequence instruction.
module host_instr_unpacker #(
  parameter int          HOST_W   = 128,
  parameter logic [3:0]  END_OP   = 4'b0000,
  parameter logic [31:0] PAD_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  host_instr_unpacker_if.master bus,
  input  logic                  flush,
  output logic                  busy,
  output logic [CNT_W-1:0]      instr_cnt,
  output logic [CNT_W-1:0]      iseq_cnt
);

  localparam int NSLOTS = HOST_W / 32;
  localparam int SLOT_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOTS - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [HOST_W-1:0]   buf_q, buf_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0]    iseq_cnt_q, iseq_cnt_d;
  logic [31:0]         cur_s;
  logic                cur_pad_s;
  logic                app_en_s;
  logic                accept_s;
  logic                is_end_s;
  logic                finished_s;
  logic                host_rd_s;

  function automatic logic [31:0] slot_word(input logic [HOST_W-1:0] w,
                                            input logic [SLOT_W-1:0] s);
    return w[32*s +: 32];
  endfunction

  // Presentation side depends only on registered state, so app_instr holds under backpressure.
  always_comb begin
    cur_s     = slot_word(buf_q, slot_q);
    cur_pad_s = (cur_s == PAD_WORD);
    app_en_s  = (state_q == ST_FULL) && !cur_pad_s;
    accept_s  = app_en_s && bus.app_ack;
    is_end_s  = (cur_s[31:28] == END_OP);
  end

  // Next-state logic: rst beats flush, flush beats normal load/consume/skip.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    slot_d      = slot_q;
    instr_cnt_d = instr_cnt_q;
    iseq_cnt_d  = iseq_cnt_q;
    host_rd_s   = 1'b0;
    finished_s  = 1'b0;
    if (rst) begin
      state_d     = ST_EMPTY;
      buf_d       = '0;
      slot_d      = '0;
      instr_cnt_d = '0;
      iseq_cnt_d  = '0;
    end else if (flush) begin
      state_d = ST_EMPTY;
      buf_d   = '0;
      slot_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (bus.host_valid) begin
            host_rd_s = 1'b1;
            buf_d     = bus.host_data;
            slot_d    = '0;
            state_d   = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (cur_pad_s || accept_s) begin
            if (accept_s) begin
              instr_cnt_d = instr_cnt_q + CNT_W'(1);
              if (is_end_s) begin
                iseq_cnt_d = iseq_cnt_q + CNT_W'(1);
              end else begin
                iseq_cnt_d = iseq_cnt_q;
              end
            end else begin
              instr_cnt_d = instr_cnt_q;
            end
            finished_s = (accept_s && is_end_s) || (slot_q == LAST_SLOT);
            // A finished word is replaced in the same cycle so the next slot 0 follows without a bubble.
            if (finished_s) begin
              slot_d = '0;
              if (bus.host_valid) begin
                host_rd_s = 1'b1;
                buf_d     = bus.host_data;
                state_d   = ST_FULL;
              end else begin
                state_d = ST_EMPTY;
              end
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          slot_d  = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    buf_q       <= buf_d;
    slot_q      <= slot_d;
    instr_cnt_q <= instr_cnt_d;
    iseq_cnt_q  <= iseq_cnt_d;
  end

  assign bus.host_rd   = host_rd_s;
  assign bus.app_en    = app_en_s;
  assign bus.app_instr = cur_s;
  assign busy          = (state_q == ST_FULL);
  assign instr_cnt     = instr_cnt_q;
  assign iseq_cnt      = iseq_cnt_q;

endmodule

// File: tb/tb_host_instr_unpacker.sv
// Table-driven bench for host_instr_unpacker with a FIFO model and an instruction scoreboard.
module tb_host_instr_unpacker;
  localparam int HOST_W = 128;
  localparam int CNT_W  = 4;
  localparam int NSL    = HOST_W / 32;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] iseq_cnt;

  host_instr_unpacker_if #(.HOST_W(HOST_W)) bus ();

  host_instr_unpacker #(
    .HOST_W  (HOST_W),
    .END_OP  (4'b0000),
    .PAD_WORD(32'hFFFF_FFFF),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .busy     (busy),
    .instr_cnt(instr_cnt),
    .iseq_cnt (iseq_cnt)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        ack;
    logic        exp_rd;
    logic        exp_en;
    logic        exp_busy;
    logic [31:0] exp_instr;
    logic [3:0]  exp_icnt;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    int          id;
  } sb_t;

  vec_t              tbl[$];
  sb_t               sb[$];
  logic [HOST_W-1:0] fifo[$];
  int                word_id = 0;
  int                n_chk   = 0;
  int                n_fail  = 0;
  int                m_icnt  = 0;
  int                m_iseq  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic f, input logic a, input logic rd,
                              input logic en, input logic bsy, input logic [31:0] instr,
                              input int icnt);
    vec_t v;
    v.rst       = r;
    v.flush     = f;
    v.ack       = a;
    v.exp_rd    = rd;
    v.exp_en    = en;
    v.exp_busy  = bsy;
    v.exp_instr = instr;
    v.exp_icnt  = 4'(icnt);
    tbl.push_back(v);
  endfunction

  // Queue a word in the FIFO and the instructions it should yield in the scoreboard.
  function automatic void push_word(input logic [HOST_W-1:0] w);
    fifo.push_back(w);
    for (int k = 0; k < NSL; k++) begin
      logic [31:0] s;
      s = w[32*k +: 32];
      if (s != 32'hFFFF_FFFF) begin
        sb_t e;
        e.instr = s;
        e.id    = word_id;
        sb.push_back(e);
        if (s[31:28] == 4'h0) break;
      end
    end
    word_id++;
  endfunction

  function automatic void drop_word();
    int id;
    if (sb.size() > 0) begin
      id = sb[0].id;
      while (sb.size() > 0 && sb[0].id == id) void'(sb.pop_front());
    end
  endfunction

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      logic rd_seen;
      sb_t  e;
      v            = tbl[i];
      rst          = v.rst;
      flush        = v.flush;
      bus.app_ack  = v.ack;
      bus.host_valid = (fifo.size() != 0);
      if (fifo.size() != 0) bus.host_data = fifo[0];
      else bus.host_data = '0;
      @(negedge clk);
      chk($sformatf("%s[%0d].host_rd", tag, i), 32'(bus.host_rd), 32'(v.exp_rd));
      chk($sformatf("%s[%0d].app_en", tag, i), 32'(bus.app_en), 32'(v.exp_en));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(v.exp_busy));
      chk($sformatf("%s[%0d].instr_cnt", tag, i), 32'(instr_cnt), 32'(v.exp_icnt));
      if (v.exp_en)
        chk($sformatf("%s[%0d].app_instr", tag, i), bus.app_instr, v.exp_instr);
      if (!v.rst && !v.flush && bus.app_en && bus.app_ack) begin
        if (sb.size() == 0) begin
          chk($sformatf("%s[%0d].sb_underflow", tag, i), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("%s[%0d].sb_instr", tag, i), bus.app_instr, e.instr);
          m_icnt++;
          if (e.instr[31:28] == 4'h0) m_iseq++;
        end
      end
      if ((v.rst || v.flush) && v.exp_busy) drop_word();
      if (v.rst) begin
        m_icnt = 0;
        m_iseq = 0;
      end
      rd_seen = bus.host_rd;
      @(posedge clk);
      #1;
      if (rd_seen && fifo.size() > 0) void'(fifo.pop_front());
    end
    tbl.delete();
    chk({tag, ".instr_cnt_model"}, 32'(instr_cnt), 32'(m_icnt % 16));
    chk({tag, ".iseq_cnt_model"}, 32'(iseq_cnt), 32'(m_iseq % 16));
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.app_ack    = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    @(posedge clk);
    #1;

    // Reset row with a word waiting (no pop under rst), then pads after two instructions.
    push_word({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2000_0003, 32'h1000_0002});
    add(1, 0, 1, 0, 0, 0, 32'h0, 0);
    add(0, 0, 1, 1, 0, 0, 32'h0, 0);
    add(0, 0, 1, 0, 1, 1, 32'h1000_0002, 0);
    add(0, 0, 1, 0, 1, 1, 32'h2000_0003, 1);
    add(0, 0, 1, 0, 0, 1, 32'h0, 2);
    add(0, 0, 1, 0, 0, 1, 32'h0, 2);
    add(0, 0, 1, 0, 0, 0, 32'h0, 2);
    run_tbl("pad");
    chk("pad.iseq_cnt", 32'(iseq_cnt), 32'd0);

    // END_OP in slot 1 discards slots 2 and 3.
    push_word({32'h6000_0009, 32'h4000_0005, 32'h0000_0000, 32'h3000_0001});
    add(0, 0, 1, 1, 0, 0, 32'h0, 2);
    add(0, 0, 1, 0, 1, 1, 32'h3000_0001, 2);
    add(0, 0, 1, 0, 1, 1, 32'h0000_0000, 3);
    add(0, 0, 1, 0, 0, 0, 32'h0, 4);
    run_tbl("endop");
    chk("endop.iseq_cnt", 32'(iseq_cnt), 32'd1);

    // Backpressure: five cycles without app_ack on slot 0.
    push_word({32'h7000_0003, 32'h7000_0002, 32'h0000_0000, 32'h1234_5678});
    add(0, 0, 0, 1, 0, 0, 32'h0, 4);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 1, 1, 32'h1234_5678, 4);
    add(0, 0, 1, 0, 1, 1, 32'h1234_5678, 4);
    add(0, 0, 1, 0, 1, 1, 32'h0000_0000, 5);
    add(0, 0, 1, 0, 0, 0, 32'h0, 6);
    run_tbl("bp");
    chk("bp.iseq_cnt", 32'(iseq_cnt), 32'd2);

    // Back-to-back words: reload on the last slot, eight consecutive app_en cycles.
    push_word({32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
    push_word({32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000});
    add(0, 0, 1, 1, 0, 0, 32'h0, 6);
    for (int k = 0; k < 4; k++) add(0, 0, 1, (k == 3), 1, 1, 32'h1000_0000 + 32'(k), 6 + k);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 1, 1, 32'h2000_0000 + 32'(k), 10 + k);
    add(0, 0, 1, 0, 0, 0, 32'h0, 14);
    run_tbl("b2b");

    // Flush at slot 2 with the next word waiting; counter wraps at 16, 17th gives 1.
    push_word({32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    push_word({32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000});
    add(0, 0, 1, 1, 0, 0, 32'h0, 14);
    add(0, 0, 1, 0, 1, 1, 32'hA000_0000, 14);
    add(0, 0, 1, 0, 1, 1, 32'hA000_0001, 15);
    add(0, 1, 1, 0, 1, 1, 32'hA000_0002, 0);
    add(0, 0, 1, 1, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 1, 1, 32'hB000_0000 + 32'(k), k);
    add(0, 0, 1, 0, 0, 0, 32'h0, 4);
    run_tbl("flush");
    chk("flush.iseq_cnt", 32'(iseq_cnt), 32'd2);

    // All-pad word, reload, then rst mid-word with another word waiting.
    push_word({4{32'hFFFF_FFFF}});
    push_word({32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
    push_word({32'hD000_0003, 32'hD000_0002, 32'h0F00_0000, 32'hD000_0000});
    add(0, 0, 1, 1, 0, 0, 32'h0, 4);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 1, 32'h0, 4);
    add(0, 0, 1, 1, 0, 1, 32'h0, 4);
    add(0, 0, 1, 0, 1, 1, 32'hC000_0000, 4);
    add(0, 0, 1, 0, 1, 1, 32'hC000_0001, 5);
    add(1, 0, 1, 0, 1, 1, 32'hC000_0002, 6);
    add(1, 0, 1, 0, 0, 0, 32'h0, 0);
    add(0, 0, 1, 1, 0, 0, 32'h0, 0);
    add(0, 0, 1, 0, 1, 1, 32'hD000_0000, 0);
    add(0, 0, 1, 0, 1, 1, 32'h0F00_0000, 1);
    add(0, 0, 1, 0, 0, 0, 32'h0, 2);
    run_tbl("rst");
    chk("rst.iseq_cnt", 32'(iseq_cnt), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("fifo_empty", 32'(fifo.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
